// File: rtl/hera_ram_arb.sv
//------------------------------------------------------------------------------
// Module   : hera_ram_arb
// Brief    : Core/debug arbiter for the single-port HERA data RAM, with
//            debug starvation guard and debug lock mode.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hera_ram_arb #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 16,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_stall_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_lock_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam logic [0:0] S_NORM   = 1'b0;
  localparam logic [0:0] S_LOCK   = 1'b1;
  localparam logic [3:0] MAX_WAIT = 4'(DBG_MAX_WAIT);

  logic [0:0] state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_vld_q, rd_vld_d;
  logic       rd_dbg_q, rd_dbg_d;
  logic       sel_dbg, sel_core;

  // Grants are suppressed entirely while reset is held.
  always_comb begin
    sel_dbg  = 1'b0;
    sel_core = 1'b0;
    if (!rst) begin
      if (state_q == S_LOCK) begin
        sel_dbg = dbg_req_i;
      end else begin
        sel_dbg  = dbg_req_i & (~core_req_i | (wait_cnt_q == MAX_WAIT));
        sel_core = core_req_i & ~sel_dbg;
      end
    end
  end

  assign dbg_gnt_o    = sel_dbg;
  assign core_stall_o = core_req_i & ~sel_core;
  assign ram_addr_o   = sel_dbg ? dbg_addr_i  : core_addr_i;
  assign ram_data_o   = sel_dbg ? dbg_wdata_i : core_wdata_i;
  assign ram_wren_o   = (sel_dbg & dbg_we_i) | (sel_core & core_we_i);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_req_i || sel_dbg) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MAX_WAIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NORM:  if (sel_dbg && dbg_lock_i) state_d = S_LOCK;
      S_LOCK:  if (!dbg_lock_i)           state_d = S_NORM;
      default: state_d = S_NORM;
    endcase
  end

  assign rd_vld_d = (sel_dbg & ~dbg_we_i) | (sel_core & ~core_we_i);
  assign rd_dbg_d = sel_dbg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_NORM;
      wait_cnt_q <= 4'd0;
      rd_vld_q   <= 1'b0;
      rd_dbg_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_dbg_q   <= rd_dbg_d;
    end
  end

  // A read tag still pending when reset arrives must not surface.
  assign core_rvalid_o = rd_vld_q & ~rd_dbg_q & ~rst;
  assign dbg_rvalid_o  = rd_vld_q &  rd_dbg_q & ~rst;
  assign core_rdata_o  = ram_q_i;
  assign dbg_rdata_o   = ram_q_i;

endmodule

`default_nettype wire
